serial_link_rx_deserializer: RTL and testbench

//  Reassembles fixed-width flits from the beat stream of serial_link_physical_rx, in the clk_i domain after the CDC FIFO.

---
 rtl/serial_link_pkg.sv | 11 +
 rtl/serial_link_rx_deserializer.sv | 62 ++++++
 tb/tb_serial_link_rx_deserializer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/serial_link_pkg.sv
// serial_link_pkg: shared serial link sizes, PHY/beat types and beats-per-flit helper
package serial_link_pkg;
  localparam int DefNumLanes = 8;
  localparam int DefDdrEn = 1;
  localparam int DefBeatWidth = DefNumLanes * (1 + DefDdrEn);
  typedef logic [DefNumLanes-1:0] phy_data_t;
  typedef logic [DefBeatWidth-1:0] beat_t;
  function automatic int beats_per_flit(input int flit_w, input int beat_w);
    return (flit_w + beat_w - 1) / beat_w;
  endfunction
endpackage

// File: rtl/serial_link_rx_deserializer.sv
// serial_link_rx_deserializer: positional reassembly of PHY RX beats into flits behind one output register
module serial_link_rx_deserializer
  import serial_link_pkg::*;
#(
  parameter int NumLanes = DefNumLanes,
  parameter int DdrEn = DefDdrEn,
  parameter int FlitWidth = 64,
  localparam int BeatWidth = NumLanes * (1 + DdrEn),
  localparam int BeatsPerFlit = beats_per_flit(FlitWidth, BeatWidth),
  localparam int IdxW = $clog2(BeatsPerFlit + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic [BeatWidth-1:0] beat_i,
  input  logic                 beat_valid_i,
  output logic                 beat_ready_o,
  output logic [FlitWidth-1:0] flit_o,
  output logic                 flit_valid_o,
  input  logic                 flit_ready_i,
  output logic [IdxW-1:0]      beat_idx_o,
  output logic [15:0]          flit_cnt_o
);
  logic [IdxW-1:0] idx_q, idx_d;
  logic [FlitWidth-1:0] asm_q, asm_d, asm_w, out_q, out_d;
  logic out_valid_q, out_valid_d;
  logic [15:0] cnt_q, cnt_d;
  logic last, acc, load, drain;
  always_comb begin
    asm_w = asm_q;
    for (int b = 0; b < FlitWidth; b++)
      if (b / BeatWidth == int'(idx_q)) asm_w[b] = beat_i[b % BeatWidth];
    last = idx_q == IdxW'(BeatsPerFlit - 1);
    beat_ready_o = clear_i | ~last | ~out_valid_q | flit_ready_i;
    acc = beat_valid_i & beat_ready_o & ~clear_i;
    load = acc & last;
    drain = out_valid_q & flit_ready_i & ~clear_i;
    idx_d = clear_i | load ? '0 : acc ? idx_q + 1'b1 : idx_q;
    asm_d = clear_i | load ? '0 : acc ? asm_w : asm_q;
    out_d = clear_i ? '0 : load ? asm_w : out_q;
    out_valid_d = ~clear_i & (load | (out_valid_q & ~flit_ready_i));
    cnt_d = drain & ~&cnt_q ? cnt_q + 16'd1 : cnt_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      idx_q <= '0;
      asm_q <= '0;
      out_q <= '0;
      out_valid_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      asm_q <= asm_d;
      out_q <= out_d;
      out_valid_q <= out_valid_d;
      cnt_q <= cnt_d;
    end
  assign flit_o = out_q;
  assign flit_valid_o = out_valid_q;
  assign beat_idx_o = idx_q;
  assign flit_cnt_o = cnt_q;
endmodule

// File: tb/tb_serial_link_rx_deserializer.sv
// tb_serial_link_rx_deserializer: randomized scoreboard bench over 64-bit, 40-bit and single-beat configurations
module tb_serial_link_rx_deserializer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int nc = 0, nf = 0, ndone = 0;
  task automatic chk(input int gi, input string nm, input logic [63:0] act, input logic [63:0] exp);
    nc++;
    if (act !== exp) begin
      nf++;
      $display("FAIL cfg%0d %s: got %h expected %h at %0t", gi, nm, act, exp, $time);
    end
  endtask
  task automatic fin();
    ndone++;
  endtask
  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int DD = g == 2 ? 0 : 1;
    localparam int FW = g == 0 ? 64 : g == 1 ? 40 : 8;
    localparam int BW = 8 * (1 + DD);
    localparam int BPF = (FW + BW - 1) / BW;
    localparam int IW = $clog2(BPF + 1);
    logic rst_n = 1'b0, clr = 1'b0, bv = 1'b0, fr = 1'b0;
    logic [BW-1:0] beat = '0;
    logic br, fv;
    logic [FW-1:0] flit;
    logic [IW-1:0] idx;
    logic [15:0] cnt;
    logic [BW-1:0] bq[$];
    logic [FW-1:0] sb[$];
    logic outv = 1'b0;
    int mcnt = 0;
    serial_link_rx_deserializer #(.NumLanes(8), .DdrEn(DD), .FlitWidth(FW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .beat_i(beat), .beat_valid_i(bv),
      .beat_ready_o(br), .flit_o(flit), .flit_valid_o(fv), .flit_ready_i(fr),
      .beat_idx_o(idx), .flit_cnt_o(cnt));
    always @(negedge clk) begin
      logic er, acc;
      logic [255:0] w;
      if (!rst_n) begin
        chk(g, "reset beat_ready", 64'(br), 64'd1);
        chk(g, "reset flit_valid", 64'(fv), 64'd0);
        chk(g, "reset flit", 64'(flit), 64'd0);
        chk(g, "reset beat_idx", 64'(idx), 64'd0);
        chk(g, "reset flit_cnt", 64'(cnt), 64'd0);
        bq.delete();
        sb.delete();
        outv = 1'b0;
      end else begin
        er = clr | !(bq.size() == BPF - 1 && outv && !fr);
        chk(g, "beat_ready", 64'(br), 64'(er));
        chk(g, "flit_valid", 64'(fv), 64'(outv));
        chk(g, "beat_idx", 64'(idx), 64'(bq.size()));
        acc = bv & er & ~clr;
        if (clr) begin
          bq.delete();
          sb.delete();
          outv = 1'b0;
        end else begin
          if (outv && fr) outv = 1'b0;
          if (acc) begin
            bq.push_back(beat);
            if (bq.size() == BPF) begin
              w = '0;
              foreach (bq[k]) w = w | (256'(bq[k]) << (k * BW));
              sb.push_back(w[FW-1:0]);
              bq.delete();
              outv = 1'b1;
            end
          end
        end
      end
    end
    always @(negedge clk) begin
      if (!rst_n) mcnt = 0;
      else begin
        chk(g, "flit_cnt", 64'(cnt), 64'(mcnt));
        if (fv && fr && !clr) begin
          if (sb.size() == 0) chk(g, "unexpected flit_valid", 64'(fv), 64'd0);
          else chk(g, "flit", 64'(flit), 64'(sb.pop_front()));
          if (mcnt < 65535) mcnt++;
        end
      end
    end
    initial begin
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < (g == 2 ? 70500 : 3000); c++) begin
        @(posedge clk);
        #1;
        if (g == 2 && c < 70000) begin
          bv = 1'b1; fr = 1'b1; clr = 1'b0; beat = BW'($urandom);
        end else if (g < 2 && c < 4) begin
          bv = 1'b1; fr = 1'b1; clr = 1'b0;
          beat = g == 0 ? BW'(32'h1111 * (c + 1)) : BW'(32'hAAAA + 32'h1111 * c);
        end else begin
          bv = $urandom_range(9) < 8;
          fr = $urandom_range(9) < 6;
          clr = $urandom_range(39) == 0;
          beat = BW'($urandom);
        end
        if (c == (g == 2 ? 70200 : 1500)) begin
          #2 rst_n = 1'b0;
          repeat (2) @(posedge clk);
          #1 rst_n = 1'b1;
        end
      end
      fin();
    end
  end
  initial begin
    fork
      wait (ndone == 3);
      #1_000_000;
    join_any
    disable fork;
    nc++;
    if (ndone != 3) begin
      nf++;
      $display("FAIL timeout: %0d of 3 configurations finished", ndone);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end
endmodule
